// File: rtl/cpu_ops_pkg.sv
// Op codes and decode helpers shared by the decoder, the forwarding unit and the hazard/stall unit.
// Also carries the hazard/stall unit's FSM state type.
package cpu_ops_pkg;

  localparam logic [3:0] OP_OR   = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } hsu_state_e;

  // addi and lw read rs1 only; op codes 1001-1111 read nothing.
  function automatic logic uses_rs2(input logic [3:0] op);
    case (op)
      OP_OR, OP_AND, OP_ADD, OP_SUB, OP_MUL, OP_SW, OP_BEQ: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_busy_counter.sv
// Down-counter for the remaining extra EX cycles of a multi-cycle mul.
// The value is loaded on entry to the busy state, decremented while busy, and flagged at zero.
module mul_busy_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_o <= '0;
    else if (load_i)
      cnt_o <= load_val_i;
    else if (dec_i && (cnt_o != '0))
      cnt_o <= cnt_o - W'(1);
  end

  assign zero_o = (cnt_o == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for hazards that forwarding cannot cover: lw->use, multi-cycle mul and
// taken-branch flush. It also keeps a wrapping count of cycles in which the PC is frozen.
module hazard_stall_unit
  import cpu_ops_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RSaddr1_i,
  input  logic [4:0]       IFID_RSaddr2_i,
  input  logic [3:0]       IFID_control_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [3:0]       IDEX_control_i,
  input  logic             IDEX_valid_i,
  input  logic             branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             IDEX_hold_o,
  output logic             EXMEM_bubble_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output hsu_state_e       state_dbg_o
);

  localparam int            MCW      = $clog2(MUL_LATENCY) + 1;
  localparam logic [MCW-1:0] MUL_LOAD = MCW'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  hsu_state_e     state, next_state;
  logic           mul_hit, load_use;
  logic           cnt_load, cnt_dec, cnt_zero;
  logic [MCW-1:0] mul_cnt;

  // IDEX_valid_i qualifies the ID/EX fields: a bubble (valid=0) never creates a hazard.
  assign mul_hit  = IDEX_valid_i && (IDEX_control_i == OP_MUL) && (MUL_LATENCY > 1);
  assign load_use = IDEX_valid_i && (IDEX_control_i == OP_LW) && (IDEX_RDaddr_i != 5'd0) &&
                    ((IDEX_RDaddr_i == IFID_RSaddr1_i) ||
                     (uses_rs2(IFID_control_i) && (IDEX_RDaddr_i == IFID_RSaddr2_i)));

  mul_busy_counter #(.W(MCW)) u_mul_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (MUL_LOAD),
    .dec_i      (cnt_dec),
    .cnt_o      (mul_cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    PCWrite_o      = 1'b1;
    IFIDWrite_o    = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    IDEX_hold_o    = 1'b0;
    EXMEM_bubble_o = 1'b0;
    next_state     = state;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    if (rst_i) begin
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (mul_hit) begin
            PCWrite_o      = 1'b0;
            IFIDWrite_o    = 1'b0;
            IDEX_hold_o    = 1'b1;
            EXMEM_bubble_o = 1'b1;
            cnt_load       = 1'b1;
            next_state     = ST_MUL_BUSY;
          end else if (load_use) begin
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEX_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            IFID_flush_o = 1'b1;
          end
        end
        ST_MUL_BUSY: begin
          // At zero the held mul leaves EX now; it is not re-detected as a new mul.
          if (!cnt_zero) begin
            PCWrite_o      = 1'b0;
            IFIDWrite_o    = 1'b0;
            IDEX_hold_o    = 1'b1;
            EXMEM_bubble_o = 1'b1;
            cnt_dec        = 1'b1;
          end else begin
            next_state = ST_RUN;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_RUN;
      stall_cycles_o <= '0;
    end else begin
      state <= next_state;
      if (!PCWrite_o)
        stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

  assign state_dbg_o = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit (MUL_LATENCY=3, CNT_W=4) with a queue-based scoreboard.
module tb_hazard_stall_unit;

  localparam logic [5:0] C_RUN  = 6'b110000; // {pcw, ifidw, flush, bubble, hold, exmem_bubble}
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_FL   = 6'b111000;
  localparam logic [5:0] C_MUL  = 6'b000011;
  localparam logic [3:0] O_ADD  = 4'b0010;
  localparam logic [3:0] O_MUL  = 4'b0100;
  localparam logic [3:0] O_ADDI = 4'b0101;
  localparam logic [3:0] O_LW   = 4'b0110;
  localparam logic [3:0] O_SW   = 4'b0111;
  localparam logic [3:0] O_BEQ  = 4'b1000;

  logic       clk, rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic [3:0] ifid_op, idex_op;
  logic       idex_valid, branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble;
  logic [3:0] stall_cycles;
  cpu_ops_pkg::hsu_state_e state_dbg;

  logic [10:0] exp_q[$];
  string       name_q[$];
  logic [3:0]  exp_cnt;
  int          checks, errors;

  hazard_stall_unit #(.MUL_LATENCY(3), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IFID_RSaddr1_i (ifid_rs1),
    .IFID_RSaddr2_i (ifid_rs2),
    .IFID_control_i (ifid_op),
    .IDEX_RDaddr_i  (idex_rd),
    .IDEX_control_i (idex_op),
    .IDEX_valid_i   (idex_valid),
    .branch_taken_i (branch_taken),
    .PCWrite_o      (pc_write),
    .IFIDWrite_o    (ifid_write),
    .IFID_flush_o   (ifid_flush),
    .IDEX_bubble_o  (idex_bubble),
    .IDEX_hold_o    (idex_hold),
    .EXMEM_bubble_o (exmem_bubble),
    .stall_cycles_o (stall_cycles),
    .state_dbg_o    (state_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs and push what the DUT must show in that cycle.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [3:0] iop, input logic [4:0] rd, input logic [3:0] eop,
                      input logic v, input logic br, input logic [5:0] ctl,
                      input logic st, input string nm);
    @(posedge clk);
    #1;
    rst = r; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_op = iop;
    idex_rd = rd; idex_op = eop; idex_valid = v; branch_taken = br;
    exp_q.push_back({ctl, st, exp_cnt});
    name_q.push_back(nm);
    if (r) exp_cnt = 4'd0;
    else if (!ctl[5]) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic idle(input logic st, input string nm);
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd9, O_ADD, 1'b1, 1'b0, C_RUN, st, nm);
  endtask

  // Monitor / scoreboard: every sampled cycle with a pending expectation is compared.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [10:0] e;
      logic [5:0]  act;
      string       nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble};
      checks++;
      if (act !== e[10:5]) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", nm, act, e[10:5]);
      end
      checks++;
      if (state_dbg !== e[4]) begin
        errors++;
        $display("FAIL %s state: got %b expected %b", nm, state_dbg, e[4]);
      end
      checks++;
      if (stall_cycles !== e[3:0]) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, e[3:0]);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; exp_cnt = 4'd0;
    rst = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; ifid_op = O_ADD;
    idex_rd = '0; idex_op = O_ADD; idex_valid = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    step(1'b1, 5'd5, 5'd5, O_ADD, 5'd5, O_MUL, 1'b1, 1'b1, C_RUN, 1'b0, "reset");
    idle(1'b0, "idle0");

    // lw->use on rs1, then rs1/rs2 filtering
    step(1'b0, 5'd5, 5'd1, O_ADD,  5'd5, O_LW, 1'b1, 1'b0, C_LU,  1'b0, "lu_rs1");
    idle(1'b0, "after_lu");
    step(1'b0, 5'd0, 5'd3, O_ADD,  5'd0, O_LW, 1'b1, 1'b0, C_RUN, 1'b0, "lu_x0");
    step(1'b0, 5'd3, 5'd5, O_ADDI, 5'd5, O_LW, 1'b1, 1'b0, C_RUN, 1'b0, "lu_addi_rs2");
    step(1'b0, 5'd3, 5'd5, O_ADD,  5'd5, O_LW, 1'b1, 1'b0, C_LU,  1'b0, "lu_add_rs2");
    step(1'b0, 5'd3, 5'd7, O_SW,   5'd7, O_LW, 1'b1, 1'b0, C_LU,  1'b0, "lu_sw_rs2");
    step(1'b0, 5'd5, 5'd5, O_ADD,  5'd5, O_LW, 1'b0, 1'b0, C_RUN, 1'b0, "lu_invalid");

    // branch flush alone and suppressed by load-use
    step(1'b0, 5'd1, 5'd2, O_BEQ, 5'd9, O_ADD, 1'b1, 1'b1, C_FL,  1'b0, "br_flush");
    step(1'b0, 5'd1, 5'd9, O_BEQ, 5'd9, O_LW,  1'b1, 1'b1, C_LU,  1'b0, "br_lu");
    idle(1'b0, "after_br");

    // single mul: 2 stall cycles then release; branch ignored while stalled
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd4, O_MUL, 1'b1, 1'b0, C_MUL, 1'b0, "mul1_a");
    step(1'b0, 5'd1, 5'd2, O_BEQ, 5'd4, O_MUL, 1'b1, 1'b1, C_MUL, 1'b1, "mul1_b_br");
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd4, O_MUL, 1'b1, 1'b0, C_RUN, 1'b1, "mul1_rel");
    idle(1'b0, "after_mul1");

    // back-to-back muls: 4 stall cycles total
    step(1'b0, 5'd1, 5'd2, O_MUL, 5'd4, O_MUL, 1'b1, 1'b0, C_MUL, 1'b0, "bb_a");
    step(1'b0, 5'd1, 5'd2, O_MUL, 5'd4, O_MUL, 1'b1, 1'b0, C_MUL, 1'b1, "bb_b");
    step(1'b0, 5'd1, 5'd2, O_MUL, 5'd4, O_MUL, 1'b1, 1'b0, C_RUN, 1'b1, "bb_rel1");
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd6, O_MUL, 1'b1, 1'b0, C_MUL, 1'b0, "bb_c");
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd6, O_MUL, 1'b1, 1'b0, C_MUL, 1'b1, "bb_d");
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd6, O_MUL, 1'b1, 1'b0, C_RUN, 1'b1, "bb_rel2");
    idle(1'b0, "after_bb");

    // reset on first busy cycle aborts the stall
    step(1'b0, 5'd1, 5'd2, O_ADD, 5'd4, O_MUL, 1'b1, 1'b0, C_MUL, 1'b0, "rst_mul_a");
    step(1'b1, 5'd1, 5'd2, O_ADD, 5'd4, O_MUL, 1'b1, 1'b0, C_RUN, 1'b1, "rst_mul_b");
    idle(1'b0, "rst_mul_after");

    // 18 load-use stalls: counter runs 0..15, wraps to 0, continues
    for (int i = 0; i < 18; i++)
      step(1'b0, 5'd8, 5'd1, O_ADD, 5'd8, O_LW, 1'b1, 1'b0, C_LU, 1'b0, $sformatf("wrap_%0d", i));
    idle(1'b0, "wrap_end");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
